// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge loader: bank-switch type codes,
// loader FSM state encoding and the recognised Atari 2600 image sizes.
package cart_pkg;

  // Bank-switch scheme codes reported on cart_type.
  typedef enum logic [2:0] {
    CART_2K      = 3'd0,
    CART_4K      = 3'd1,
    CART_F8      = 3'd2,
    CART_FA      = 3'd3,
    CART_F6      = 3'd4,
    CART_F4      = 3'd5,
    CART_GENERIC = 3'd6,
    CART_UNKNOWN = 3'd7
  } cart_type_e;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  // Image sizes that map onto a known bank-switch scheme.
  localparam logic [15:0] SIZE_2K  = 16'd2048;
  localparam logic [15:0] SIZE_4K  = 16'd4096;
  localparam logic [15:0] SIZE_8K  = 16'd8192;
  localparam logic [15:0] SIZE_12K = 16'd12288;
  localparam logic [15:0] SIZE_16K = 16'd16384;
  localparam logic [15:0] SIZE_32K = 16'd32768;

  // The address mask never covers less than a 2K window.
  localparam int MIN_MASK_LOG2 = 11;

endpackage

// File: rtl/cart_detect.sv
// Combinational image classifier: maps an image length onto the 2600
// bank-switch scheme and the power-of-two address mask that covers it.
// Only meaningful for lengths 1..2**ADDR_W; the loader filters the rest.
module cart_detect
  import cart_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic [15:0]       len_i,
  output logic [2:0]        cart_type_o,
  output logic [ADDR_W-1:0] cart_mask_o
);

  logic [31:0] len_ext;

  assign len_ext = {16'd0, len_i};

  // Exact-size lookup for the scheme; anything else is a generic image.
  always_comb begin
    case (len_i)
      SIZE_2K:  cart_type_o = CART_2K;
      SIZE_4K:  cart_type_o = CART_4K;
      SIZE_8K:  cart_type_o = CART_F8;
      SIZE_12K: cart_type_o = CART_FA;
      SIZE_16K: cart_type_o = CART_F6;
      SIZE_32K: cart_type_o = CART_F4;
      default:  cart_type_o = CART_GENERIC;
    endcase
  end

  // Smallest 2**k >= len (k >= 11), minus one. Scanning k downward lets the
  // last hit be the tightest window; the full address range is the fallback.
  always_comb begin
    cart_mask_o = '1;
    for (int k = ADDR_W - 1; k >= MIN_MASK_LOG2; k--) begin
      if (len_ext <= (32'd1 << k)) begin
        cart_mask_o = ADDR_W'((32'd1 << k) - 32'd1);
      end
    end
  end

endmodule

// File: rtl/cart_loader.sv
// Cartridge loader: waits for an SPI download to finish, latches the byte
// count and menu index, classifies the image, then copies it byte by byte
// from the download RAM into cartridge memory over a req/ack write port.
// busy holds the console core off while a download or copy is underway.
// MAX_SIZE is expected to equal 2**ADDR_W.
module cart_loader
  import cart_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int MAX_SIZE = 32768
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              downloading,
  input  logic [15:0]       size,
  input  logic [7:0]        index,
  output logic [ADDR_W-1:0] ram_a,
  input  logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        cart_type,
  output logic [ADDR_W-1:0] cart_mask,
  output logic [7:0]        cart_index
);

  localparam logic [31:0] MAX_LEN = 32'(MAX_SIZE);

  state_e              state_q, state_d;
  logic                dl_q;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic [ADDR_W:0]     ptr_inc;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [2:0]          cart_type_q, cart_type_d;
  logic [ADDR_W-1:0]   cart_mask_q, cart_mask_d;
  logic [7:0]          cart_index_q, cart_index_d;

  logic                rise;
  logic                fall;
  logic                size_bad;
  logic [2:0]          det_type;
  logic [ADDR_W-1:0]   det_mask;

  assign rise     = downloading & ~dl_q;
  assign fall     = ~downloading & dl_q;
  assign size_bad = (size == 16'd0) || ({16'd0, size} > MAX_LEN);
  // The pointer is one bit wider than an address so a full 2**ADDR_W image
  // can count to its length without wrapping.
  assign ptr_inc  = ptr_q + {{ADDR_W{1'b0}}, 1'b1};

  // Classifier sees the live size; its result is captured on the fall edge.
  cart_detect #(
    .ADDR_W (ADDR_W)
  ) u_detect (
    .len_i       (size),
    .cart_type_o (det_type),
    .cart_mask_o (det_mask)
  );

  // State and output registers; everything returns to idle on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      dl_q         <= 1'b0;
      len_q        <= '0;
      ptr_q        <= '0;
      ram_a_q      <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cart_type_q  <= CART_UNKNOWN;
      cart_mask_q  <= '0;
      cart_index_q <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= downloading;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      ram_a_q      <= ram_a_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_req_q    <= mem_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cart_type_q  <= cart_type_d;
      cart_mask_q  <= cart_mask_d;
      cart_index_q <= cart_index_d;
    end
  end

  // Next-state and output logic; a new download start overrides any state.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    ptr_d        = ptr_q;
    ram_a_d      = ram_a_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_req_d    = mem_req_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    cart_type_d  = cart_type_q;
    cart_mask_d  = cart_mask_q;
    cart_index_d = cart_index_q;

    if (rise) begin
      // Abort whatever copy was running and wait for the new image.
      state_d   = ST_LOADING;
      busy_d    = 1'b1;
      done_d    = 1'b0;
      error_d   = 1'b0;
      mem_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_LOADING: begin
          if (fall) begin
            len_d        = size;
            cart_index_d = index;
            if (size_bad) begin
              state_d     = ST_IDLE;
              error_d     = 1'b1;
              done_d      = 1'b0;
              busy_d      = 1'b0;
              cart_type_d = CART_UNKNOWN;
            end else begin
              state_d     = ST_READ;
              ptr_d       = '0;
              // Address is presented on entry to READ so the RAM data is
              // already valid throughout WAIT.
              ram_a_d     = '0;
              cart_type_d = det_type;
              cart_mask_d = det_mask;
            end
          end
        end

        ST_READ: begin
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          state_d    = ST_WRITE;
          mem_addr_d = ptr_q[ADDR_W-1:0];
          mem_data_d = ram_dout;
          mem_req_d  = 1'b1;
        end

        ST_WRITE: begin
          // addr/data/req are held until the acknowledge is seen.
          if (mem_ack) begin
            mem_req_d = 1'b0;
            ptr_d     = ptr_inc;
            if (32'(ptr_inc) == 32'(len_q)) begin
              state_d = ST_FINISH;
            end else begin
              state_d = ST_READ;
              ram_a_d = ptr_inc[ADDR_W-1:0];
            end
          end
        end

        ST_FINISH: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign ram_a      = ram_a_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_req    = mem_req_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cart_type  = cart_type_q;
  assign cart_mask  = cart_mask_q;
  assign cart_index = cart_index_q;

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Downstream consumer of the SPI download buffer.
- Watches the download-active flag, latches the final byte count and menu index, then copies every byte from the download RAM's CPU port into cartridge memory over a req/ack write port.
- Derives the Atari 2600 bank-switch type and address mask from the image size.
- Sits between the download buffer and the cartridge ROM/SDRAM controller; the console core is held off via busy.

Parameters:
- ADDR_W, 15, width of download-RAM and cartridge-memory byte addresses.
- MAX_SIZE, 32768, largest accepted image in bytes; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; download flag/size/index are already synchronised to it.
- reset_n  in  1  asynchronous active-low reset.
- downloading  in  1  download in progress.
- size  in  16  bytes received; valid once downloading falls.
- index  in  8  file/menu index of the download.
- ram_a  out  ADDR_W  read address to download-RAM CPU port.
- ram_dout  in  8  read data; valid exactly 1 clk after ram_a.
- mem_addr  out  ADDR_W  cartridge memory write address.
- mem_data  out  8  cartridge memory write data.
- mem_req  out  1  write request.
- mem_ack  in  1  write accepted.
- busy  out  1  download or copy in progress; console held in reset.
- done  out  1  image loaded (sticky until next download).
- error  out  1  last image rejected (sticky until next download).
- cart_type  out  3  bank-switch scheme of loaded image.
- cart_mask  out  ADDR_W  size rounded up to a power of two, minus 1.
- cart_index  out  8  index latched at download end.

Behaviour:
- Reset values: ram_a=0, mem_addr=0, mem_data=0, mem_req=0, busy=0, done=0, error=0, cart_type=7, cart_mask=0, cart_index=0. FSM state is IDLE. The downloading edge register resets to 0.
- Edge detect: register downloading once, giving dl_q. rise = downloading & ~dl_q. fall = ~downloading & dl_q.
- rise, in any state: go to LOADING. Set busy=1, done=0, error=0, mem_req=0. Any copy in progress is aborted.
- LOADING:
  - On fall, latch len=size and cart_index=index.
  - If len==0 or len>MAX_SIZE: go to IDLE, error=1, done=0, busy=0, cart_type=7.
  - Otherwise: set ptr=0 and go to READ.
- READ: ram_a=ptr, next state WAIT.
- WAIT: 1-cycle RAM latency, next state WRITE.
- WRITE:
  - On entry, mem_addr=ptr, mem_data=ram_dout, mem_req=1.
  - addr, data and req stay stable until mem_ack is sampled high.
  - mem_ack may be high on the first cycle of req. Minimum is 1 cycle per write.
  - On ack: mem_req=0 next cycle and ptr=ptr+1 (ADDR_W+1 bits, no wrap).
  - If ptr+1==len: go to FINISH, else go to READ.
  - Throughput: at most one byte per 3 clk plus ack wait.
- FINISH: done=1, busy=0, then IDLE.
- cart_type, written at fall (valid lengths):
  - 2048 -> 0 (2K)
  - 4096 -> 1 (4K)
  - 8192 -> 2 (F8)
  - 12288 -> 3 (FA)
  - 16384 -> 4 (F6)
  - 32768 -> 5 (F4)
  - any other valid length -> 6 (generic, copied anyway, error=0)
- cart_mask: smallest 2**k >= len, minus 1, with k >= 11. Example: len=12288 gives mask 0x3FFF.
- mem_ack while mem_req=0 is ignored.
- downloading held low at reset release: no action.
- Reset asserted mid-copy: all outputs return to reset values immediately. No further mem_req.

Decomposition:
- Shared package cart_pkg:
  - cart type codes CART_2K..CART_UNKNOWN
  - FSM state encoding
  - size constants 2048/4096/8192/12288/16384/32768
- One sub-module, cart_detect: combinational len -> {cart_type, cart_mask}. It is instanced once and registered at fall.

Test Plan:
- 4096-byte download (pattern byte i = i[7:0]), mem_ack tied high:
  - exactly 4096 mem_req writes at addr 0..4095 with matching data
  - then done=1, busy=0, cart_type=1, cart_mask=0x0FFF
- 8192-byte download, mem_ack delayed 0–5 random cycles:
  - addr and data held stable during wait
  - no duplicate or skipped addresses
  - cart_type=2, done=1
- size=0 and size=40000 downloads:
  - no mem_req
  - error=1, done=0, busy=0, cart_type=7
- Second download rising at byte 100 of a 16384-byte copy:
  - mem_req drops within 1 clk, done=0, busy stays 1
  - new 2048-byte image copies fully
  - cart_type=0, cart_mask=0x07FF
- reset_n low at byte 50 of a copy:
  - all outputs at reset values asynchronously
  - no mem_req after release until a new download completes
- 12288-byte download with index=0x03:
  - cart_type=3, cart_mask=0x3FFF, cart_index=0x03
  - last write at addr 12287
